// File: rtl/pc_stack_ctrl.sv
// Program counter with hardware LIFO return stack and single-level interrupt entry.
// Interrupt entry saves the held PC, so reti resumes at the interrupted instruction.
module pc_stack_ctrl #(
  parameter int                  PC_WIDTH     = 12,
  parameter int                  STACK_DEPTH  = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0] INT_VECTOR   = PC_WIDTH'(4),
  parameter int                  SKIP_INC     = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pause,
  input  logic                             interrupt,
  input  logic                             skip,
  input  logic                             goto,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             reti,
  input  logic [PC_WIDTH-1:0]              goto_addr,
  output logic [PC_WIDTH-1:0]              pc_out,
  output logic                             int_ack,
  output logic                             in_service,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             overflow_err,
  output logic                             underflow_err
);
  localparam int CW = $clog2(STACK_DEPTH+1);
  localparam int AW = $clog2(STACK_DEPTH);
  localparam logic [PC_WIDTH-1:0] SKIP_W = PC_WIDTH'(SKIP_INC);
  localparam logic [PC_WIDTH-1:0] ONE_W  = PC_WIDTH'(1);

  typedef enum logic [1:0] {RUN, INT_WAIT, INT_SAVE} state_t;

  state_t                                state, state_nxt;
  logic [STACK_DEPTH-1:0][PC_WIDTH-1:0]  stk;
  logic [PC_WIDTH-1:0]                   pc_nxt, push_data;
  logic [CW-1:0]                         cnt_nxt;
  logic [AW-1:0]                         wr_idx, rd_idx;
  logic                                  svc_nxt, ack_nxt, push, pop;

  assign wr_idx = stack_count[AW-1:0];
  assign rd_idx = AW'(stack_count - CW'(1));

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_out;
    svc_nxt   = in_service;
    ack_nxt   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_out + ONE_W;
    case (state)
      RUN: begin
        if (interrupt && !in_service)
          state_nxt = skip ? INT_SAVE : INT_WAIT;
        else if (skip)
          pc_nxt = pc_out + SKIP_W;
        else if (goto)
          pc_nxt = goto_addr;
        else if (call) begin
          push   = 1'b1;
          pc_nxt = goto_addr;
        end else if (reti || ret) begin
          // popping an empty stack restarts at the reset vector
          pop    = 1'b1;
          pc_nxt = stack_empty ? RESET_VECTOR : stk[rd_idx];
          if (reti) svc_nxt = 1'b0;
        end else
          pc_nxt = pc_out + ONE_W;
      end
      INT_WAIT: state_nxt = INT_SAVE;
      INT_SAVE: begin
        push      = 1'b1;
        push_data = pc_out;
        pc_nxt    = INT_VECTOR;
        svc_nxt   = 1'b1;
        ack_nxt   = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    cnt_nxt = stack_count;
    if (push && !stack_full)
      cnt_nxt = stack_count + CW'(1);
    else if (pop && !stack_empty)
      cnt_nxt = stack_count - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      pc_out        <= RESET_VECTOR;
      in_service    <= 1'b0;
      int_ack       <= 1'b0;
      stack_count   <= '0;
      stack_full    <= 1'b0;
      stack_empty   <= 1'b1;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (!pause) begin
      state       <= state_nxt;
      pc_out      <= pc_nxt;
      in_service  <= svc_nxt;
      int_ack     <= ack_nxt;
      stack_count <= cnt_nxt;
      stack_full  <= (cnt_nxt == CW'(STACK_DEPTH));
      stack_empty <= (cnt_nxt == '0);
      if (push && stack_full)  overflow_err  <= 1'b1;
      if (pop  && stack_empty) underflow_err <= 1'b1;
    end
  end

  // Stack storage has no reset; stack_count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && !pause && push && !stack_full)
      stk[wr_idx] <= push_data;
  end

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Directed bench for pc_stack_ctrl with default parameters (12-bit PC, depth 8).
module tb_pc_stack_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pause = 1'b0, interrupt = 1'b0, skip = 1'b0, goto = 1'b0;
  logic        call = 1'b0, ret = 1'b0, reti = 1'b0;
  logic [11:0] goto_addr = '0;
  logic [11:0] pc_out;
  logic        int_ack, in_service, stack_full, stack_empty;
  logic        overflow_err, underflow_err;
  logic [3:0]  stack_count;

  int vectors = 0;
  int miscompares = 0;

  pc_stack_ctrl dut (
    .clk(clk), .reset(reset), .pause(pause), .interrupt(interrupt),
    .skip(skip), .goto(goto), .call(call), .ret(ret), .reti(reti),
    .goto_addr(goto_addr), .pc_out(pc_out), .int_ack(int_ack),
    .in_service(in_service), .stack_count(stack_count),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [11:0] a);
    goto = 1'b1; goto_addr = a;
    step();
    goto = 1'b0;
    vectors++; if (pc_out !== a) begin miscompares++; $display("FAIL goto pc=%h exp=%h", pc_out, a); end
  endtask

  task automatic test_reset();
    #12;
    vectors++; if (pc_out !== 12'h000) begin miscompares++; $display("FAIL rst_pc pc=%h exp=000", pc_out); end
    vectors++; if (stack_count !== 4'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0) begin
      miscompares++; $display("FAIL rst_stack cnt=%0d empty=%b full=%b exp 0/1/0", stack_count, stack_empty, stack_full); end
    vectors++; if (in_service !== 1'b0 || int_ack !== 1'b0 || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      miscompares++; $display("FAIL rst_flags svc=%b ack=%b ovf=%b unf=%b exp 0", in_service, int_ack, overflow_err, underflow_err); end
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      vectors++; if (pc_out !== 12'(i)) begin miscompares++; $display("FAIL count pc=%h exp=%h", pc_out, 12'(i)); end
    end
    reset = 1'b1; #1; reset = 1'b0;
    step(); step(); step();
    vectors++; if (pc_out !== 12'h003) begin miscompares++; $display("FAIL count3 pc=%h exp=003", pc_out); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (pc_out !== 12'h000) begin miscompares++; $display("FAIL async_rst pc=%h exp=000", pc_out); end
    #1 reset = 1'b0;
  endtask

  task automatic test_interrupt();
    jump(12'h010);
    interrupt = 1'b1;
    step();
    interrupt = 1'b0;
    vectors++; if (pc_out !== 12'h010) begin miscompares++; $display("FAIL int_hold1 pc=%h exp=010", pc_out); end
    step();
    vectors++; if (pc_out !== 12'h010 || int_ack !== 1'b0) begin miscompares++; $display("FAIL int_hold2 pc=%h ack=%b exp=010/0", pc_out, int_ack); end
    step();
    vectors++; if (pc_out !== 12'h004) begin miscompares++; $display("FAIL int_vec pc=%h exp=004", pc_out); end
    vectors++; if (int_ack !== 1'b1 || stack_count !== 4'd1 || in_service !== 1'b1) begin
      miscompares++; $display("FAIL int_entry ack=%b cnt=%0d svc=%b exp 1/1/1", int_ack, stack_count, in_service); end
    step();
    vectors++; if (int_ack !== 1'b0 || pc_out !== 12'h005) begin miscompares++; $display("FAIL int_ack_pulse ack=%b pc=%h exp 0/005", int_ack, pc_out); end
    reti = 1'b1;
    step();
    reti = 1'b0;
    vectors++; if (pc_out !== 12'h010 || in_service !== 1'b0 || stack_count !== 4'd0) begin
      miscompares++; $display("FAIL reti pc=%h svc=%b cnt=%0d exp 010/0/0", pc_out, in_service, stack_count); end
  endtask

  task automatic test_skip_int();
    jump(12'h020);
    skip = 1'b1; interrupt = 1'b1;
    step();
    skip = 1'b0; interrupt = 1'b0;
    vectors++; if (pc_out !== 12'h020) begin miscompares++; $display("FAIL skipint_hold pc=%h exp=020", pc_out); end
    step();
    vectors++; if (pc_out !== 12'h004 || int_ack !== 1'b1 || in_service !== 1'b1) begin
      miscompares++; $display("FAIL skipint_vec pc=%h ack=%b svc=%b exp 004/1/1", pc_out, int_ack, in_service); end
    interrupt = 1'b1;
    step();
    interrupt = 1'b0;
    vectors++; if (pc_out !== 12'h005) begin miscompares++; $display("FAIL nest_ign1 pc=%h exp=005", pc_out); end
    step();
    vectors++; if (pc_out !== 12'h006 || stack_count !== 4'd1 || int_ack !== 1'b0) begin
      miscompares++; $display("FAIL nest_ign2 pc=%h cnt=%0d ack=%b exp 006/1/0", pc_out, stack_count, int_ack); end
    reti = 1'b1;
    step();
    reti = 1'b0;
    vectors++; if (pc_out !== 12'h020 || in_service !== 1'b0) begin miscompares++; $display("FAIL skipint_reti pc=%h svc=%b exp 020/0", pc_out, in_service); end
  endtask

  task automatic test_call_ret();
    jump(12'h030);
    call = 1'b1; goto_addr = 12'hABC;
    step();
    call = 1'b0;
    vectors++; if (pc_out !== 12'hABC || stack_count !== 4'd1) begin miscompares++; $display("FAIL call pc=%h cnt=%0d exp ABC/1", pc_out, stack_count); end
    ret = 1'b1;
    step();
    ret = 1'b0;
    vectors++; if (pc_out !== 12'h031 || stack_empty !== 1'b1) begin miscompares++; $display("FAIL ret pc=%h empty=%b exp 031/1", pc_out, stack_empty); end
    jump(12'hFFF);
    step();
    vectors++; if (pc_out !== 12'h000) begin miscompares++; $display("FAIL wrap pc=%h exp=000", pc_out); end
  endtask

  task automatic test_overflow_underflow();
    logic [11:0] exp_push [8];
    logic [11:0] pc_exp, tgt;
    jump(12'h200);
    pc_exp = 12'h200;
    for (int i = 0; i < 9; i++) begin
      tgt = 12'h300 + 12'(i * 16);
      if (i < 8) exp_push[i] = pc_exp + 12'h001;
      call = 1'b1; goto_addr = tgt;
      step();
      pc_exp = tgt;
      vectors++; if (pc_out !== tgt) begin miscompares++; $display("FAIL call_pc[%0d] pc=%h exp=%h", i, pc_out, tgt); end
      vectors++; if (stack_count !== 4'((i < 8) ? i + 1 : 8) || stack_full !== (i >= 7) || overflow_err !== (i == 8)) begin
        miscompares++; $display("FAIL call_stat[%0d] cnt=%0d full=%b ovf=%b", i, stack_count, stack_full, overflow_err); end
    end
    call = 1'b0;
    ret = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      vectors++; if (pc_out !== exp_push[7-j] || stack_count !== 4'(7 - j)) begin
        miscompares++; $display("FAIL ret_lifo[%0d] pc=%h cnt=%0d exp %h/%0d", j, pc_out, stack_count, exp_push[7-j], 7 - j); end
      vectors++; if (underflow_err !== 1'b0) begin miscompares++; $display("FAIL unf_early[%0d] unf=%b exp=0", j, underflow_err); end
    end
    step();
    ret = 1'b0;
    vectors++; if (pc_out !== 12'h000 || underflow_err !== 1'b1 || stack_count !== 4'd0 || stack_empty !== 1'b1) begin
      miscompares++; $display("FAIL underflow pc=%h unf=%b cnt=%0d empty=%b exp 000/1/0/1", pc_out, underflow_err, stack_count, stack_empty); end
    vectors++; if (overflow_err !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky ovf=%b exp=1", overflow_err); end
  endtask

  task automatic test_pause();
    jump(12'h050);
    pause = 1'b1; goto = 1'b1; goto_addr = 12'h123; interrupt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (pc_out !== 12'h050 || stack_count !== 4'd0 || in_service !== 1'b0 || int_ack !== 1'b0) begin
        miscompares++; $display("FAIL pause[%0d] pc=%h cnt=%0d svc=%b ack=%b exp 050/0/0/0", i, pc_out, stack_count, in_service, int_ack); end
    end
    pause = 1'b0; goto = 1'b0; interrupt = 1'b0;
    step();
    vectors++; if (pc_out !== 12'h051) begin miscompares++; $display("FAIL pause_resume pc=%h exp=051", pc_out); end
    step();
    vectors++; if (pc_out !== 12'h052) begin miscompares++; $display("FAIL pause_fsm pc=%h exp=052", pc_out); end
    // Freeze in the middle of interrupt entry.
    jump(12'h060);
    interrupt = 1'b1;
    step();
    interrupt = 1'b0; pause = 1'b1;
    step(); step();
    vectors++; if (pc_out !== 12'h060 || int_ack !== 1'b0 || stack_count !== 4'd0) begin
      miscompares++; $display("FAIL pause_intwait pc=%h ack=%b cnt=%0d exp 060/0/0", pc_out, int_ack, stack_count); end
    pause = 1'b0;
    step();
    vectors++; if (pc_out !== 12'h060) begin miscompares++; $display("FAIL intsave_hold pc=%h exp=060", pc_out); end
    step();
    vectors++; if (pc_out !== 12'h004 || int_ack !== 1'b1 || stack_count !== 4'd1) begin
      miscompares++; $display("FAIL pause_vec pc=%h ack=%b cnt=%0d exp 004/1/1", pc_out, int_ack, stack_count); end
    reti = 1'b1;
    step();
    reti = 1'b0;
    vectors++; if (pc_out !== 12'h060 || in_service !== 1'b0) begin miscompares++; $display("FAIL pause_reti pc=%h svc=%b exp 060/0", pc_out, in_service); end
  endtask

  task automatic test_err_clear();
    #2 reset = 1'b1;
    #1;
    vectors++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0 || pc_out !== 12'h000) begin
      miscompares++; $display("FAIL err_clear ovf=%b unf=%b pc=%h exp 0/0/000", overflow_err, underflow_err, pc_out); end
    #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_skip_int();
    test_call_ret();
    test_overflow_underflow();
    test_pause();
    test_err_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_stack_ctrl.md
Name: pc_stack_ctrl

Overview:
Parametrised program counter with a hardware LIFO return stack for the ez8-class CPU. It is the successor to the fixed 12-bit PC controller. It adds configurable PC width, stack depth and vectors, plus `call`/`reti` commands, nested-interrupt blocking, stack status and sticky overflow/underflow error flags. `pc_out` drives the instruction-fetch address directly.

Parameters:
PC_WIDTH, 12, width of PC, goto_addr and stack entries
STACK_DEPTH, 8, number of return-stack entries (>=2)
RESET_VECTOR, 0, PC value after reset and after an underflowing pop
INT_VECTOR, 4, PC value loaded on interrupt entry
SKIP_INC, 1, increment applied by skip (1 or 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pause  in  1  freeze all state while high
interrupt  in  1  interrupt request, sampled in RUN
skip  in  1  skip command
goto  in  1  jump command
call  in  1  jump and push return address
ret  in  1  pop the return address
reti  in  1  pop the return address and end the interrupt service
goto_addr  in  PC_WIDTH  target address for goto/call
pc_out  out  PC_WIDTH  current PC / fetch address
int_ack  out  1  one-cycle pulse on vector load
in_service  out  1  interrupt being serviced
stack_count  out  $clog2(STACK_DEPTH+1)  valid stack entries
stack_full  out  1  stack_count==STACK_DEPTH
stack_empty  out  1  stack_count==0
overflow_err  out  1  sticky: push attempted while full
underflow_err  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (asynchronous, any state):
  - pc_out=RESET_VECTOR; FSM=RUN; stack_count=0; in_service=0; int_ack=0; both error flags=0.
  - Stack contents are don't-care.
- All outputs are registered.
- All PC arithmetic is modulo 2^PC_WIDTH (wraps).
- pause=1: no register changes, including the FSM. Commands and interrupt are ignored that cycle.
- FSM states: RUN, INT_WAIT, INT_SAVE.
- RUN, interrupt accepted (interrupt=1 and in_service=0):
  - PC holds.
  - skip=1 -> INT_SAVE; else -> INT_WAIT.
  - All other commands that cycle are discarded.
- RUN, interrupt=1 and in_service=1: interrupt is ignored (no nesting, no latching). The cycle proceeds as a normal RUN cycle.
- INT_WAIT: PC holds; -> INT_SAVE. Inputs are ignored.
- INT_SAVE:
  - Push pc_out; pc_out<=INT_VECTOR; in_service<=1; int_ack=1 for the following cycle; -> RUN.
  - Inputs are ignored.
- RUN without an accepted interrupt, priority highest first:
  1. skip: pc+SKIP_INC.
  2. goto: goto_addr.
  3. call: push pc+1, pc<=goto_addr.
  4. reti: pop to pc, in_service<=0.
  5. ret: pop to pc.
  6. Otherwise: pc+1.
- Latency: every command takes effect on pc_out one cycle after the sampling edge. Interrupt entry shows INT_VECTOR 3 edges after sampling (2 via skip).
- Stack is a true LIFO; pop returns the most recent push.
- Push while full: entry dropped, stack_count unchanged, overflow_err<=1. The PC change still occurs.
- Pop while empty: pc<=RESET_VECTOR, underflow_err<=1, stack_count stays 0. reti still clears in_service.
- Error flags clear only on reset.
- stack_full and stack_empty track stack_count in the same cycle.

Test Plan:
1. Reset, then 5 free-running cycles -> pc_out 0,1,2,3,4,5. Assert reset mid-count at pc=3 -> pc_out=0 immediately (asynchronous).
2. Run to pc=0x010; interrupt pulse 1 cycle ->
   - pc_out holds 0x010 for 2 cycles, then reads 0x004.
   - int_ack pulses; stack_count=1; in_service=1.
   - After reti: pc_out=0x010, in_service=0.
3. skip+interrupt together at pc=0x020 -> pc_out holds 1 cycle, then 0x004. A second interrupt while in_service -> ignored, pc increments normally.
4. call goto_addr=0xABC at pc=0x030 -> pc_out=0xABC, stack top=0x031. ret -> pc_out=0x031. goto 0xFFF then 1 idle cycle -> pc_out=0x000 (wrap).
5. STACK_DEPTH=8: perform 9 calls -> stack_full=1 after 8, overflow_err=1 on the 9th, stack_count=8. Then 9 rets -> 8 correct LIFO addresses, 9th gives pc_out=RESET_VECTOR and underflow_err=1.
6. pause=1 for 3 cycles with goto/interrupt asserted -> pc_out, FSM and stack unchanged. Release pause -> counting resumes from the held value.
